// File: rtl/anc_pkg.sv
// Types and constants shared by the ANC front end: sample type, I2S receiver
// FSM states and capture widths.
package anc_pkg;
  localparam int DATA_BITS = 24;
  localparam int OUT_BITS  = 16;

  typedef logic signed [OUT_BITS-1:0] sample_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_LEFT,
    ST_RIGHT
  } i2s_state_t;
endpackage

// File: rtl/i2s_clkgen.sv
// I2S bit clock / word select generator. Strobes rise/fall mark the clk edge on
// which bclk toggles; everything parks at zero while run is low.
module i2s_clkgen #(
  parameter int BCLK_HALF = 16,
  parameter int SLOT_BITS = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  output logic       bclk,
  output logic       ws,
  output logic       rise,
  output logic       fall,
  output logic [5:0] bit_idx
);
  localparam logic [7:0] DIV_LAST = 8'(BCLK_HALF - 1);
  localparam logic [5:0] BIT_LAST = 6'(SLOT_BITS - 1);

  logic [7:0] div_cnt;
  logic       wrap;

  assign wrap = run && (div_cnt == DIV_LAST);
  assign rise = wrap && !bclk;
  assign fall = wrap && bclk;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      ws      <= 1'b0;
      bit_idx <= '0;
    end else if (!run) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      ws      <= 1'b0;
      bit_idx <= '0;
    end else begin
      div_cnt <= wrap ? 8'd0 : div_cnt + 8'd1;
      if (wrap) bclk <= ~bclk;
      // ws only ever moves together with a bclk fall
      if (fall) begin
        if (bit_idx == BIT_LAST) begin
          bit_idx <= '0;
          ws      <= ~ws;
        end else begin
          bit_idx <= bit_idx + 6'd1;
        end
      end
    end
  end
endmodule

// File: rtl/mic_i2s_rx.sv
// I2S microphone receiver: drives bclk/ws, captures the 24-bit left word and
// delivers a rounded, saturated 16-bit sample with a one-cycle ready strobe.
module mic_i2s_rx
  import anc_pkg::*;
#(
  parameter int BCLK_HALF = 16,
  parameter int SLOT_BITS = 32
) (
  input  logic               clk_in,
  input  logic               rst_n_in,
  input  logic               en_in,
  output logic               bclk_out,
  output logic               ws_out,
  input  logic               sd_in,
  output logic signed [15:0] sample_out,
  output logic               ready_out
);
  localparam logic [5:0] BIT_LAST = 6'(SLOT_BITS - 1);
  localparam logic [5:0] CAP_LAST = 6'(DATA_BITS);

  function automatic sample_t round_sat(input logic signed [DATA_BITS-1:0] d);
    logic [OUT_BITS-1:0] hi;
    logic                half;
    hi   = d[DATA_BITS-1:DATA_BITS-OUT_BITS];
    half = d[DATA_BITS-OUT_BITS-1];
    if (hi == 16'h7FFF && half) return sample_t'(16'h7FFF);
    return sample_t'(hi + {15'd0, half});
  endfunction

  logic rst_meta, rst_n_sync;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rst_meta   <= 1'b0;
      rst_n_sync <= 1'b0;
    end else begin
      rst_meta   <= 1'b1;
      rst_n_sync <= rst_meta;
    end
  end

  i2s_state_t state, state_nxt;
  logic       rise, fall, slot_end, run;
  logic [5:0] bit_idx;

  assign run      = (state != ST_IDLE);
  assign slot_end = fall && (bit_idx == BIT_LAST);

  i2s_clkgen #(
    .BCLK_HALF(BCLK_HALF),
    .SLOT_BITS(SLOT_BITS)
  ) u_clkgen (
    .clk    (clk_in),
    .rst_n  (rst_n_sync),
    .run    (run),
    .bclk   (bclk_out),
    .ws     (ws_out),
    .rise   (rise),
    .fall   (fall),
    .bit_idx(bit_idx)
  );

  always_ff @(posedge clk_in or negedge rst_n_sync) begin
    if (!rst_n_sync) state <= ST_IDLE;
    else             state <= state_nxt;
  end

  // Stopping is only honoured at a frame boundary (end of the right slot)
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (en_in) state_nxt = ST_SYNC;
      ST_SYNC:  if (slot_end && ws_out) state_nxt = en_in ? ST_LEFT : ST_IDLE;
      ST_LEFT:  if (slot_end) state_nxt = ST_RIGHT;
      ST_RIGHT: if (slot_end) state_nxt = en_in ? ST_LEFT : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  logic                        drop_p0, vld_p0, cap_bit;
  logic signed [DATA_BITS-1:0] shreg_p0;

  assign cap_bit = rise && (state == ST_LEFT) && (bit_idx != 6'd0) && (bit_idx <= CAP_LAST);

  // Stage p0: shift in left-slot bits; drop_p0 remembers an en_in dropout in
  // this left slot so a partial word is never emitted
  always_ff @(posedge clk_in or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      shreg_p0 <= '0;
      drop_p0  <= 1'b0;
      vld_p0   <= 1'b0;
    end else begin
      if (cap_bit) shreg_p0 <= {shreg_p0[DATA_BITS-2:0], sd_in};
      if (slot_end && state != ST_LEFT) drop_p0 <= 1'b0;
      else if (state == ST_LEFT && !en_in) drop_p0 <= 1'b1;
      vld_p0 <= rise && (state == ST_LEFT) && (bit_idx == CAP_LAST) && en_in && !drop_p0;
    end
  end

  // Stage p1: round/saturate and publish
  always_ff @(posedge clk_in or negedge rst_n_sync) begin
    if (!rst_n_sync) begin
      sample_out <= '0;
      ready_out  <= 1'b0;
    end else begin
      ready_out <= vld_p0;
      if (vld_p0) sample_out <= round_sat(shreg_p0);
    end
  end
endmodule

// File: doc/mic_i2s_rx.md
MIC_I2S_RX -- requirements
Module: mic_i2s_rx

Interface
REQ-001 SHALL have parameter BCLK_HALF, default 16, clk_in cycles per bclk_out half-period (legal values 2..255).
REQ-002 SHALL have parameter SLOT_BITS, default 32, bclk periods per channel slot (legal values 26..64).
REQ-003 SHALL have port clk_in, input, 1, single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst_n_in, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port en_in, input, 1, run enable; when low, clocks park and no samples are produced.
REQ-006 SHALL have port bclk_out, output, 1, I2S bit clock to microphone.
REQ-007 SHALL have port ws_out, output, 1, I2S word select (0 = left slot, 1 = right slot).
REQ-008 SHALL have port sd_in, input, 1, microphone serial data; it is sampled on the bclk_out rising-edge event.
REQ-009 SHALL have port sample_out, output, 16 signed, latest left-channel sample; feeds x_in of the ANC top level.
REQ-010 SHALL have port ready_out, output, 1, one-clk_in pulse marking a new sample_out; feeds ready_in of the ANC top level.

Function
REQ-011 SHALL run a divider counter 0..BCLK_HALF-1 and toggle bclk_out when it wraps; a 0->1 toggle is the "rise event" and a 1->0 toggle is the "fall event".
REQ-012 SHALL count bit index 0..SLOT_BITS-1 on each fall event, wrapping to 0 and toggling ws_out at the wrap, so ws_out changes only on fall events.
REQ-013 SHALL implement FSM IDLE -> SYNC -> LEFT <-> RIGHT.
REQ-014 IDLE: outputs are parked (bclk_out=0, ws_out=0, counters=0); the FSM moves to SYNC when en_in=1.
REQ-015 SYNC: the FSM discards the first full frame and enters LEFT at the first ws_out 1->0 transition, so no partial sample is ever emitted.
REQ-016 LEFT: on the rise event with bit index k, for 1<=k<=24, the block SHALL shift sd_in into a 24-bit register, MSB first; the k=0 delay bit and k>=25 are ignored.
REQ-017 When ws_out goes 0->1, the FSM moves LEFT->RIGHT; RIGHT ignores sd_in and returns to LEFT at ws_out 1->0.
REQ-018 On the rise event capturing bit 24, the block SHALL compute the rounded value r = d[23:8] + d[7], saturating to 0x7FFF when d[23:8] = 0x7FFF and d[7] = 1 (negative values cannot overflow).
REQ-019 sample_out SHALL update to r on the clk_in edge following the bit-24 rise event; ready_out SHALL be high for exactly that one cycle.
REQ-020 sample_out SHALL hold its value between updates; ready_out SHALL never be high on two consecutive cycles.
REQ-021 When en_in falls mid-frame, the block SHALL finish the current frame through the last RIGHT bit, then enter IDLE; a sample already captured in that frame is still emitted, and a partial one is discarded.
REQ-022 When en_in rises while the block is finishing a frame after en_in fell, it SHALL continue without passing through IDLE or SYNC.
REQ-023 Sample rate SHALL be f_clk / (4*BCLK_HALF*SLOT_BITS); with defaults at 100 MHz, this is 48.828 kHz.

Reset
REQ-024 While rst_n_in=0, the block SHALL hold state=IDLE, bclk_out=0, ws_out=0, sample_out=0, ready_out=0, and all counters and the shift register at 0.
REQ-025 Reset assertion SHALL take effect immediately (asynchronously) at any point, including mid-slot; deassertion is synchronised with a 2-flop synchroniser before first use.
REQ-026 After deassertion, the first ready_out SHALL occur only after the full SYNC frame has been discarded.

Structure
REQ-027 The shared package anc_pkg SHALL hold typedef sample_t (signed 16), the FSM state enum i2s_state_t, and the constants DATA_BITS=24 and OUT_BITS=16.
REQ-028 The bclk/ws generator SHALL be a sub-module i2s_clkgen, which outputs the rise and fall event pulses and the bit index; capture, rounding and the FSM stay in mic_i2s_rx.

Verification
REQ-029 Defaults, en_in=1, left word 0x123456 -> sample_out=0x1234 with a one-cycle ready_out, 1 clk after the bit-24 rise event.
REQ-030 Left word 0x1234C0 -> 0x1235 (rounded up); left word 0x7FFFFF -> 0x7FFF (saturated); left word 0x800000 -> 0x8000.
REQ-031 Right-slot data 0xFFFFFF with left-slot data 0x000000 -> sample_out=0x0000, proving the right slot is ignored.
REQ-032 Period check: ready_out pulses are exactly 2048 clk_in cycles apart, and bclk_out high and low times are each 16 cycles.
REQ-033 en_in dropped during left bit 10 -> no ready_out for that frame and bclk_out parked low after the frame ends; en_in reasserted -> one discarded SYNC frame, then samples resume.
REQ-034 rst_n_in pulsed low for 1 cycle mid-LEFT slot -> all outputs 0 within the same cycle, and the first ready_out appears only after the SYNC frame.
